// File: rtl/compound_eval_sched.sv
// Round-robin scheduler that time-shares one combinational compound_circuits block among NREQ requesters.
// A granted vector is held on cc_in for SETTLE cycles, then the result is returned over a valid/ready channel.
module compound_eval_sched #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned IDW    = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*6-1:0]   req_vec,
  output logic [NREQ-1:0]     gnt,
  output logic [5:0]          cc_in,
  input  logic [4:0]          cc_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [4:0]          rsp_data,
  output logic                busy
);

  localparam int unsigned VW = 6;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  if (SETTLE < 1) begin : g_bad_settle
    $error("compound_eval_sched: SETTLE must be >= 1");
  end
  if (NREQ < 2) begin : g_bad_nreq
    $error("compound_eval_sched: NREQ must be >= 2");
  end
  if (IDW != $clog2(NREQ)) begin : g_bad_idw
    $error("compound_eval_sched: IDW must equal clog2(NREQ)");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [VW-1:0]   cc_in_q, cc_in_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [RW-1:0]   rsp_data_q, rsp_data_d;
  logic            busy_q, busy_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [VW-1:0]   vec_arr [NREQ];
  logic            win_found;
  logic [IDW-1:0]  win_idx;
  int unsigned     pos;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign vec_arr[i] = req_vec[i*VW +: VW];
  end

  // First requesting index at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    pos       = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      pos = 32'(rr_ptr_q) + off;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!win_found && req[IDW'(pos)]) begin
        win_found = 1'b1;
        win_idx   = IDW'(pos);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      cc_in_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cc_in_q     <= cc_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (win_found) state_d = ST_SETTLE;
      ST_SETTLE: if (cnt_q == '0) state_d = ST_RESP;
      ST_RESP:   if (rsp_valid_q && rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath updates; cc_in keeps the last granted vector until the next grant
  always_comb begin
    gnt_d       = '0;
    cc_in_d     = cc_in_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    busy_d      = busy_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          gnt_d    = NREQ'(1) << win_idx;
          cc_in_d  = vec_arr[win_idx];
          rsp_id_d = win_idx;
          cnt_d    = CW'(SETTLE - 1);
          rr_ptr_d = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
          busy_d   = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          rsp_data_d  = cc_out;
          rsp_valid_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign gnt       = gnt_q;
  assign cc_in     = cc_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_compound_eval_sched.sv
// Scoreboard bench for compound_eval_sched: directed grant/response expectations pushed by the driver,
// popped and compared by independent monitors.
module tb_compound_eval_sched;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned IDW    = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [4:0]     data;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [5:0]        vec0 = '0, vec1 = '0, vec2 = '0, vec3 = '0;
  logic [NREQ*6-1:0] req_vec;
  logic [NREQ-1:0]   gnt;
  logic [5:0]        cc_in;
  logic [4:0]        cc_out;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [IDW-1:0]    rsp_id;
  logic [4:0]        rsp_data;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int gnt_cyc = 0;
  logic prev_v = 1'b0;

  logic [NREQ-1:0] exp_gnt_q [$];
  rsp_t            exp_rsp_q [$];

  assign req_vec = {vec3, vec2, vec1, vec0};

  // Stand-in compound_circuits: a=bit5 .. f=bit0, outputs {y1..y5}
  function automatic logic [4:0] cc_model(input logic [5:0] v);
    logic a, b, c, d, e, f;
    {a, b, c, d, e, f} = v;
    return {a & b, c & d, ~(e | f), ~(c | d), ~(a | b)};
  endfunction
  assign cc_out = cc_model(cc_in);

  compound_eval_sched #(.NREQ(NREQ), .SETTLE(SETTLE), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_vec(req_vec), .gnt(gnt),
    .cc_in(cc_in), .cc_out(cc_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Grant monitor
  always @(negedge clk) begin
    if (rst_n && gnt != '0) begin
      gnt_cyc = cyc;
      if (exp_gnt_q.size() == 0) begin
        check("unexpected_gnt", 32'(gnt), 32'(0));
      end else begin
        check("gnt_order", 32'(gnt), 32'(exp_gnt_q.pop_front()));
      end
    end
  end

  // Response monitor: one pop per accepted response
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_rsp_q.size() == 0) begin
        check("unexpected_rsp", 32'({rsp_id, rsp_data}), 32'(0));
      end else begin
        e = exp_rsp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
  end

  // Latency monitor: rsp_valid rises SETTLE cycles after the grant pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (rsp_valid && !prev_v) check("latency", 32'(cyc - gnt_cyc), SETTLE);
      prev_v = rsp_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (gnt != '0) seen = 1'b1;
    end
    if (!seen) check("gnt_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_valid();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    if (!seen) check("valid_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (!busy && !rsp_valid) seen = 1'b1;
    end
    if (!seen) check("idle_timeout", 32'(0), 32'(1));
  endtask

  task automatic push(input logic [NREQ-1:0] g, input logic [IDW-1:0] id, input logic [4:0] d);
    exp_gnt_q.push_back(g);
    exp_rsp_q.push_back('{id: id, data: d});
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_cc_in", 32'(cc_in), 32'(0));
    check("rst_valid", 32'(rsp_valid), 32'(0));
    check("rst_id", 32'(rsp_id), 32'(0));
    check("rst_data", 32'(rsp_data), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // Single request
    vec0 = 6'b110000;
    push(4'b0001, 2'd0, 5'b10110);
    req = 4'b0001;
    wait_gnt();
    check("single_gnt", 32'(gnt), 32'(4'b0001));
    check("single_cc_in", 32'(cc_in), 32'(6'b110000));
    req = '0;
    tick();
    check("gnt_pulse", 32'(gnt), 32'(0));
    wait_idle();

    // Reset in the middle of SETTLE drops the transaction
    vec1 = 6'b111111;
    exp_gnt_q.push_back(4'b0010);
    req = 4'b0010;
    wait_gnt();
    req = '0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_gnt", 32'(gnt), 32'(0));
    check("midrst_cc_in", 32'(cc_in), 32'(0));
    check("midrst_valid", 32'(rsp_valid), 32'(0));
    check("midrst_id", 32'(rsp_id), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_no_valid", 32'(rsp_valid), 32'(0));
    end

    // Round robin with all requesters active
    vec0 = 6'b000000; vec1 = 6'b111111; vec2 = 6'b110000; vec3 = 6'b000000;
    push(4'b0001, 2'd0, 5'b00111);
    push(4'b0010, 2'd1, 5'b11000);
    push(4'b0100, 2'd2, 5'b10110);
    push(4'b1000, 2'd3, 5'b00111);
    push(4'b0001, 2'd0, 5'b00111);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_gnt();
    req = '0;
    wait_idle();

    // Backpressure; a request arriving in RESP waits for the next IDLE
    rsp_ready = 1'b0;
    vec2 = 6'b110000;
    push(4'b0100, 2'd2, 5'b10110);
    req = 4'b0100;
    wait_gnt();
    req = '0;
    wait_valid();
    vec0 = 6'b000000;
    req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'(1));
      check("bp_id", 32'(rsp_id), 32'(2));
      check("bp_data", 32'(rsp_data), 32'(5'b10110));
      check("bp_busy", 32'(busy), 32'(1));
      check("bp_no_gnt", 32'(gnt), 32'(0));
      tick();
    end
    push(4'b0001, 2'd0, 5'b00111);
    rsp_ready = 1'b1;
    tick();
    check("bp_rel_valid", 32'(rsp_valid), 32'(0));
    check("bp_rel_busy", 32'(busy), 32'(0));
    check("bp_rel_gnt", 32'(gnt), 32'(0));
    tick();
    check("bp_next_gnt", 32'(gnt), 32'(4'b0001));
    req = '0;
    wait_idle();

    // Withdrawn request: asserted in RESP, dropped before IDLE
    rsp_ready = 1'b0;
    push(4'b0010, 2'd1, 5'b11000);
    req = 4'b0010;
    wait_gnt();
    req = '0;
    wait_valid();
    req = 4'b0100;
    tick(); tick();
    req = '0;
    tick();
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("wd_no_gnt", 32'(gnt), 32'(0));
    end

    // Pointer wrap: grant 3, then 0 wins over 3
    vec3 = 6'b111111; vec0 = 6'b110000;
    push(4'b1000, 2'd3, 5'b11000);
    req = 4'b1000;
    wait_gnt();
    req = '0;
    wait_idle();
    push(4'b0001, 2'd0, 5'b10110);
    req = 4'b1001;
    wait_gnt();
    check("wrap_gnt", 32'(gnt), 32'(4'b0001));
    req = '0;
    wait_idle();
    tick(); tick();

    check("gnt_q_drained", 32'(exp_gnt_q.size()), 32'(0));
    check("rsp_q_drained", 32'(exp_rsp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
